// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer that starts drawing clients in fixed
// priority order and muxes the granted client onto the registered frame-buffer write port.
module frame_draw_scheduler #(
    parameter int          NUM_CLIENTS    = 4,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic [3:0]  client_mask,
    output logic [3:0]  client_start,
    input  logic [3:0]  client_done,
    input  logic [35:0] client_x,
    input  logic [31:0] client_y,
    input  logic [47:0] client_color,
    input  logic [3:0]  client_we,
    output logic [8:0]  outX,
    output logic [7:0]  outY,
    output logic [11:0] color,
    output logic        writeEn,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        timeout
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;
    localparam logic [2:0] LAST = 3'(NUM_CLIENTS);
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] mask_q, mask_d;
    logic [19:0] cnt_q, cnt_d;
    logic overrun_q, overrun_d, timeout_q, timeout_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [11:0] c_q, c_d;
    logic we_q, we_d;
    logic [3:0][8:0] xs;
    logic [3:0][7:0] ys;
    logic [3:0][11:0] cs;
    logic [1:0] sel;
    logic done_hit, cnt_hit;
    assign xs = client_x;
    assign ys = client_y;
    assign cs = client_color;
    assign sel = idx_q[1:0];
    assign done_hit = client_done[sel];
    assign cnt_hit = cnt_q == TIMEOUT_CYCLES - 20'd1;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        mask_d = mask_q;
        cnt_d = cnt_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q | (frame_tick & (state_q != S_IDLE));
        x_d = x_q;
        y_d = y_q;
        c_d = c_q;
        we_d = 1'b0;
        case (state_q)
            S_IDLE: if (frame_tick) begin
                mask_d = client_mask;
                idx_d = 3'd0;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = (idx_q == LAST) ? S_DONE : mask_q[sel] ? S_START : S_NEXT;
                idx_d = (idx_q != LAST && !mask_q[sel]) ? idx_q + 3'd1 : idx_q;
            end
            S_START: begin
                cnt_d = 20'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                x_d = xs[sel];
                y_d = ys[sel];
                c_d = cs[sel];
                we_d = client_we[sel];
                cnt_d = cnt_q + {19'd0, cnt_q != '1};
                // done wins over a coincident timeout, so the flag only marks real stalls
                if (done_hit || cnt_hit) begin
                    idx_d = idx_q + 3'd1;
                    state_d = S_NEXT;
                    timeout_d = timeout_q | ~done_hit;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q <= 3'd0;
            mask_q <= 4'd0;
            cnt_q <= 20'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            x_q <= 9'd0;
            y_q <= 8'd0;
            c_q <= 12'd0;
            we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            mask_q <= mask_d;
            cnt_q <= cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            x_q <= x_d;
            y_q <= y_d;
            c_q <= c_d;
            we_q <= we_d;
        end
    end
    assign client_start = (state_q == S_START) ? 4'b0001 << sel : 4'b0000;
    assign frame_done = state_q == S_DONE;
    assign busy = state_q != S_IDLE;
    assign overrun = overrun_q;
    assign timeout = timeout_q;
    assign outX = x_q;
    assign outY = y_q;
    assign color = c_q;
    assign writeEn = we_q;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: scoreboard bench; a behavioural client model answers start
// pulses while a monitor checks starts and frame-buffer writes against queued expectations.
module tb_frame_draw_scheduler;
    localparam int TO = 16;
    logic clk = 1'b0, resetn = 1'b0, frame_tick = 1'b0;
    logic [3:0] client_mask = 4'd0, client_done = 4'd0, client_we = 4'd0, client_start;
    logic [8:0] wx[4];
    logic [7:0] wy[4];
    logic [11:0] wc[4];
    logic [35:0] client_x;
    logic [31:0] client_y;
    logic [47:0] client_color;
    logic [8:0] outX;
    logic [7:0] outY;
    logic [11:0] color;
    logic writeEn, busy, frame_done, overrun, timeout;
    int checks = 0, errors = 0;
    int sq[$];
    logic [28:0] wq[$];
    int e_start;
    logic [28:0] e_wr;
    bit mon_wr = 1'b1;
    int dly[4];
    bit wr[4];
    int rogue_we = -1, rogue_done = -1;
    int dur, extra, btail;

    assign client_x = {wx[3], wx[2], wx[1], wx[0]};
    assign client_y = {wy[3], wy[2], wy[1], wy[0]};
    assign client_color = {wc[3], wc[2], wc[1], wc[0]};
    always #5 clk = ~clk;

    frame_draw_scheduler #(.NUM_CLIENTS(4), .TIMEOUT_CYCLES(20'd16)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .client_mask(client_mask),
        .client_start(client_start), .client_done(client_done), .client_x(client_x),
        .client_y(client_y), .client_color(client_color), .client_we(client_we),
        .outX(outX), .outY(outY), .color(color), .writeEn(writeEn), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .timeout(timeout)
    );

    always @(negedge clk) begin
        if (client_start != 4'd0) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL start_order: got %b, expected no start", client_start);
            end else begin
                e_start = sq.pop_front();
                if (client_start !== 4'(1 << e_start)) begin
                    errors++;
                    $display("FAIL start_order: got %b, expected client %0d", client_start, e_start);
                end
            end
        end
        if (mon_wr && writeEn === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_port: got x=%0d y=%0d c=%h, expected no write", outX, outY, color);
            end else begin
                e_wr = wq.pop_front();
                if ({outX, outY, color} !== e_wr) begin
                    errors++;
                    $display("FAIL write_port: got %h, expected %h", {outX, outY, color}, e_wr);
                end
            end
        end
    end

    function automatic int flen(input logic [3:0] m);
        int s = 2;
        for (int i = 0; i < 4; i++)
            s += m[i] ? 2 + ((dly[i] < 0 || dly[i] > TO) ? TO : dly[i]) : 1;
        return s;
    endfunction

    task automatic set_cfg(input int d);
        for (int i = 0; i < 4; i++) begin
            dly[i] = d;
            wr[i] = 1'b0;
            wx[i] = 9'(i + 1);
            wy[i] = 8'(i + 1);
            wc[i] = 12'(i + 1);
        end
        rogue_we = -1;
        rogue_done = -1;
    endtask

    task automatic run_frame(input logic [3:0] mask, input int tick_at, output int d, output int ex, output int bt);
        int act, cnt;
        act = -1; cnt = 0; d = 0; ex = 0; bt = 0;
        for (int i = 0; i < 4; i++) if (mask[i]) sq.push_back(i);
        client_mask = mask;
        frame_tick = 1'b1;
        for (int t = 1; t <= 400 && d == 0; t++) begin
            @(negedge clk);
            client_done = 4'd0;
            client_we = 4'd0;
            frame_tick = (t == tick_at);
            if (t == 3) client_mask = ~mask;
            if (rogue_we >= 0) client_we[rogue_we] = 1'b1;
            if (rogue_done >= 0) client_done[rogue_done] = 1'b1;
            if (frame_done === 1'b1) d = t;
            if (client_start != 4'd0) begin
                for (int i = 0; i < 4; i++) if (client_start[i]) act = i;
                cnt = 0;
            end else if (act >= 0) begin
                cnt++;
                if (wr[act] && cnt == 2) begin
                    client_we[act] = 1'b1;
                    wq.push_back({wx[act], wy[act], wc[act]});
                end
                if (cnt == dly[act]) begin
                    client_done[act] = 1'b1;
                    act = -1;
                end
            end
        end
        if (d == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_bound: no frame_done within 400 cycles, expected one");
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            client_done = 4'd0;
            client_we = 4'd0;
            if (frame_done === 1'b1) ex++;
            if (busy === 1'b1) bt++;
        end
    endtask

    task automatic check_frame(input string name, input int exp_dur);
        checks++;
        if (dur !== exp_dur) begin errors++; $display("FAIL %s_len: got %0d, expected %0d", name, dur, exp_dur); end
        checks++;
        if (extra !== 0 || btail !== 0) begin errors++; $display("FAIL %s_tail: got done=%0d busy=%0d, expected 0 0", name, extra, btail); end
        checks++;
        if (sq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got starts=%0d writes=%0d left, expected 0 0", name, sq.size(), wq.size());
        end
        sq.delete();
        wq.delete();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({client_start, outX, outY, color, writeEn, busy, frame_done, overrun, timeout} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", {client_start, outX, outY, color, writeEn, busy, frame_done, overrun, timeout});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_mask;
        set_cfg(10);
        run_frame(4'b0000, 0, dur, extra, btail);
        check_frame("empty", 6);
    endtask

    task automatic test_all_clients;
        set_cfg(10);
        run_frame(4'b1111, 0, dur, extra, btail);
        check_frame("all", flen(4'b1111));
        checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL all_flags: got ov=%b to=%b, expected 0 0", overrun, timeout); end
    endtask

    task automatic test_write_mux;
        set_cfg(6);
        wr[0] = 1'b1; wx[0] = 9'd7; wy[0] = 8'd200; wc[0] = 12'h123;
        wr[3] = 1'b1; wx[3] = 9'd100; wy[3] = 8'd15; wc[3] = 12'hFFF;
        wx[1] = 9'd511; wy[1] = 8'd255; wc[1] = 12'hABC;
        rogue_we = 1;
        run_frame(4'b1001, 0, dur, extra, btail);
        check_frame("write", flen(4'b1001));
    endtask

    task automatic test_foreign_done;
        set_cfg(8);
        rogue_done = 3;
        run_frame(4'b0011, 0, dur, extra, btail);
        check_frame("foreign_done", flen(4'b0011));
    endtask

    task automatic test_done_at_timeout;
        set_cfg(5);
        dly[2] = TO;
        run_frame(4'b0100, 0, dur, extra, btail);
        check_frame("edge_done", flen(4'b0100));
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL edge_done_flag: got to=%b, expected 0", timeout); end
    endtask

    task automatic test_timeout;
        set_cfg(5);
        dly[2] = -1;
        wr[2] = 1'b1;
        run_frame(4'b1100, 0, dur, extra, btail);
        check_frame("timeout", flen(4'b1100));
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b, expected 1", timeout); end
        set_cfg(4);
        run_frame(4'b0001, 0, dur, extra, btail);
        check_frame("sticky", flen(4'b0001));
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, expected 1", timeout); end
    endtask

    task automatic test_overrun_mid;
        set_cfg(10);
        run_frame(4'b1111, 17, dur, extra, btail);
        check_frame("overrun", flen(4'b1111));
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b, expected 1", overrun); end
    endtask

    task automatic test_flags_cleared;
        test_reset();
        checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL flag_clear: got ov=%b to=%b, expected 0 0", overrun, timeout); end
    endtask

    task automatic test_tick_at_done;
        set_cfg(10);
        run_frame(4'b0000, 6, dur, extra, btail);
        check_frame("tick_done", 6);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL tick_done_flag: got %b, expected 1", overrun); end
    endtask

    task automatic test_reset_mid_wait;
        int n;
        set_cfg(10);
        mon_wr = 1'b0;
        wx[0] = 9'd300; wy[0] = 8'd99; wc[0] = 12'h5A5;
        client_we = 4'b0001;
        client_mask = 4'b0001;
        sq.push_back(0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n = 0;
        while (writeEn !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (writeEn !== 1'b1) begin errors++; $display("FAIL rst_wait_write: got writeEn=%b, expected 1", writeEn); end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({client_start, outX, outY, color, writeEn, busy, frame_done, overrun, timeout} !== 39'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h, expected 0", {client_start, outX, outY, color, writeEn, busy, frame_done, overrun, timeout});
        end
        resetn = 1'b1;
        client_we = 4'd0;
        @(negedge clk);
        checks++;
        if (client_start !== 4'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got start=%b done=%b busy=%b, expected 0 0 0", client_start, frame_done, busy);
        end
        sq.delete();
        mon_wr = 1'b1;
    endtask

    initial begin
        set_cfg(10);
        @(negedge clk);
        test_reset();
        test_empty_mask();
        test_all_clients();
        test_write_mux();
        test_foreign_done();
        test_done_at_timeout();
        test_overrun_mid();
        test_flags_cleared();
        test_tick_at_done();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
